// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sa_pkg
//  Description : Shared types and constants for the systolic array
//                sequencer: FSM state encoding, row tag type and the
//                valid/tag pipe geometry helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package sa_pkg;

  localparam int SA_N     = 4;
  localparam int SA_M_MAX = 64;
  localparam int SA_ROW_W = $clog2(SA_M_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } sa_state_e;

  typedef logic [SA_ROW_W-1:0] sa_row_tag_t;

  // Buffer cycle + N accumulator stages + A register + (N-1) column hops.
  function automatic int sa_pipe_depth(input int n);
    return 2 * n + 1;
  endfunction

  // Stage (1 = pushed one cycle ago) at which column c's result appears.
  function automatic int sa_res_tap(input int n, input int c);
    return n + 2 + c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sa_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sa_ctrl_if
//  Description : Job command, buffer strobe and result tag bundle of the
//                systolic array sequencer. perf_cycles exists only when
//                SA_CTRL_PERF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sa_ctrl_if #(
  parameter int N     = 4,
  parameter int ROW_W = 6,
  parameter int NW    = 2
);
  logic             start;
  logic [ROW_W:0]   cfg_m;
  logic             cfg_reuse_w;
  logic             busy;
  logic             done;
  logic             err;
  logic             w_rd_en;
  logic [NW-1:0]    w_rd_row;
  logic             weight_load_en;
  logic             compute_en;
  logic             a_rd_en;
  logic [ROW_W-1:0] a_rd_row;
  logic [N-1:0]     res_valid;
  logic [N*ROW_W-1:0] res_row;
`ifdef SA_CTRL_PERF_EN
  logic [31:0]      perf_cycles;
`endif

  modport master (
    output start, cfg_m, cfg_reuse_w,
    input  busy, done, err, w_rd_en, w_rd_row, weight_load_en, compute_en,
           a_rd_en, a_rd_row, res_valid, res_row
`ifdef SA_CTRL_PERF_EN
    , input perf_cycles
`endif
  );

  modport slave (
    input  start, cfg_m, cfg_reuse_w,
    output busy, done, err, w_rd_en, w_rd_row, weight_load_en, compute_en,
           a_rd_en, a_rd_row, res_valid, res_row
`ifdef SA_CTRL_PERF_EN
    , output perf_cycles
`endif
  );
endinterface
`default_nettype wire

// File: rtl/sa_valid_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : sa_valid_pipe
//  Description : Shift register of {valid, row tag} that follows each A row
//                through the array, tapped per column at the array bottom.
//                empty_next says the pipe will hold nothing after this shift
//                (assuming no push this cycle).
//  Revision    : 1.0 - initial release
// ============================================================================
module sa_valid_pipe
  import sa_pkg::*;
#(
  parameter int N     = SA_N,
  parameter int TAG_W = SA_ROW_W
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               push_valid,
  input  wire logic [TAG_W-1:0]   push_tag,
  output logic      [N-1:0]       tap_valid,
  output logic      [N*TAG_W-1:0] tap_tag,
  output logic                    empty_next
);
  localparam int DEPTH = sa_pipe_depth(N);

  // Stage s holds the entry pushed s cycles ago.
  logic [DEPTH:1]            valid_q, valid_d;
  logic [DEPTH:1][TAG_W-1:0] tag_q, tag_d;

  // Shift one stage per cycle; idle cycles shift in zeros.
  always_comb begin
    valid_d = {valid_q[DEPTH-1:1], push_valid};
    tag_d   = {tag_q[DEPTH-1:1], push_tag};
  end

  // Pipe registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  // The last stage drops out on this shift, so only the others matter.
  assign empty_next = ~|valid_q[DEPTH-1:1];

  for (genvar c = 0; c < N; c++) begin : g_tap
    localparam int S = sa_res_tap(N, c);
    assign tap_valid[c]               = valid_q[S];
    assign tap_tag[c*TAG_W +: TAG_W]  = tag_q[S];
  end

endmodule
`default_nettype wire

// File: rtl/systolic_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_array_ctrl
//  Description : Job sequencer for an N x N weight-stationary systolic
//                array: preload weights bottom row first, stream M A rows,
//                tag de-skewed results per column. Optional SA_CTRL_PERF_EN
//                adds a 32-bit busy-cycle counter (perf_cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_array_ctrl
  import sa_pkg::*;
#(
  parameter int N     = SA_N,
  parameter int M_MAX = SA_M_MAX,
  parameter int ROW_W = $clog2(M_MAX),
  parameter int NW    = $clog2(N)
) (
  input  wire logic clk,
  input  wire logic rst,
  sa_ctrl_if.slave  bus
);
  localparam int CNT_W = ((ROW_W > NW) ? ROW_W : NW) + 1;

  sa_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W:0]   m_q, m_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             cfg_ok;
  logic             accept;
  logic             w_rd_en, weight_load_en, compute_en, a_rd_en;
  logic [NW-1:0]    w_rd_row;
  logic [ROW_W-1:0] a_rd_row;
  logic             pipe_empty_next;

  assign cfg_ok = (bus.cfg_m != '0) && (bus.cfg_m <= (ROW_W+1)'(M_MAX));

  // Next-state, counters and per-state strobes.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    m_d            = m_q;
    done_d         = 1'b0;
    err_d          = 1'b0;
    accept         = 1'b0;
    w_rd_en        = 1'b0;
    w_rd_row       = '0;
    weight_load_en = 1'b0;
    compute_en     = 1'b0;
    a_rd_en        = 1'b0;
    a_rd_row       = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (cfg_ok) begin
            accept  = 1'b1;
            m_d     = bus.cfg_m;
            cnt_d   = '0;
            state_d = bus.cfg_reuse_w ? STREAM : LOAD_W;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD_W: begin
        // Bottom weight row goes in first; load enable trails the read by
        // the buffer's one-cycle latency.
        w_rd_en        = (cnt_q < CNT_W'(N));
        weight_load_en = (cnt_q != '0);
        if (w_rd_en) w_rd_row = NW'(N - 1) - cnt_q[NW-1:0];
        if (cnt_q == CNT_W'(N)) begin
          cnt_d   = '0;
          state_d = STREAM;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STREAM: begin
        compute_en = 1'b1;
        a_rd_en    = 1'b1;
        a_rd_row   = cnt_q[ROW_W-1:0];
        if (cnt_q == CNT_W'(m_q) - CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        compute_en = 1'b1;
        if (pipe_empty_next) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  sa_valid_pipe #(
    .N     (N),
    .TAG_W (ROW_W)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .push_valid (a_rd_en),
    .push_tag   (a_rd_row),
    .tap_valid  (bus.res_valid),
    .tap_tag    (bus.res_row),
    .empty_next (pipe_empty_next)
  );

  assign bus.busy           = (state_q != IDLE);
  assign bus.done           = done_q;
  assign bus.err            = err_q;
  assign bus.w_rd_en        = w_rd_en;
  assign bus.w_rd_row       = w_rd_row;
  assign bus.weight_load_en = weight_load_en;
  assign bus.compute_en     = compute_en;
  assign bus.a_rd_en        = a_rd_en;
  assign bus.a_rd_row       = a_rd_row;

`ifdef SA_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Busy-cycle count: restart on accept, hold while idle.
  always_comb begin
    perf_d = perf_q;
    if (accept)                perf_d = '0;
    else if (state_q != IDLE)  perf_d = perf_q + 32'd1;
  end

  // Performance counter register.
  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign bus.perf_cycles = perf_q;
`endif

endmodule
`default_nettype wire

// File: doc/systolic_array_ctrl.md
Name: systolic_array_ctrl

Overview:
Sequencer for an N x N weight-stationary systolic array of PEs (A flows right, partial sums flow down, B held stationary). It accepts a job command, preloads N weight rows through the top of the array, streams M rows of A, and tags the de-skewed bottom-row results with per-column valid and row index. External A/W buffers have a fixed 1-cycle read latency, which the controller accounts for. The A input skew (column k delayed k cycles) is done outside this block.

Parameters:
N, 4, array dimension (rows = columns)
M_MAX, 64, maximum A rows per job
ROW_W, $clog2(M_MAX), width of the A row index
NW, $clog2(N), width of the weight row index

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  job request; accepted only when busy=0
cfg_m  in  ROW_W+1  number of A rows for the job, 1..M_MAX
cfg_reuse_w  in  1  1 = skip weight load and keep resident weights
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end
err  out  1  one-cycle pulse when a start is rejected
w_rd_en  out  1  weight buffer read strobe
w_rd_row  out  NW  weight row address
weight_load_en  out  1  to all PEs; also selects weight (1) or 0 (0) at the array top input_B
compute_en  out  1  to all PEs; high in STREAM and DRAIN
a_rd_en  out  1  A buffer read strobe
a_rd_row  out  ROW_W  A row address
res_valid  out  N  per-column result valid at the array bottom
res_row  out  N*ROW_W  per-column A row index, column c at bits [c*ROW_W +: ROW_W]

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE.
  - All outputs are 0.
  - The valid/tag pipe is cleared.
  - Reset mid-job aborts the job with no done pulse.
- States: IDLE, LOAD_W, STREAM, DRAIN.
- IDLE:
  - start=1 with 1<=cfg_m<=M_MAX: latch cfg_m and cfg_reuse_w, busy=1 next cycle.
  - Next state is STREAM if cfg_reuse_w=1, else LOAD_W.
  - start=1 with cfg_m=0 or cfg_m>M_MAX: err pulse next cycle, stay IDLE.
- start while busy=1 is ignored, with no err.
- LOAD_W: lasts N+1 cycles, local index i=0..N.
  - w_rd_en=(i<N) and w_rd_row=N-1-i, so the bottom row is loaded first.
  - weight_load_en=(i>=1), i.e. w_rd_en delayed one cycle to match the read latency.
  - Then go to STREAM.
- STREAM: lasts cfg_m cycles, index m=0..cfg_m-1.
  - a_rd_en=1, a_rd_row=m, compute_en=1, weight_load_en=0.
  - Each read pushes valid=1 and tag=m into the tag pipe.
  - Then go to DRAIN.
- Result timing: a row read at cycle t gives column c's result at the array bottom at t+N+2+c. This is 1 buffer cycle + N row accumulator stages + 1 A register + c column hops.
  - The pipe has depth N+2+(N-1) = 2N+1.
  - res_valid[c] and res_row[c] tap the pipe at stage N+2+c.
- DRAIN:
  - compute_en=1, a_rd_en=0; the pipe shifts in zeros.
  - Leave when the pipe is empty.
  - done pulses on the cycle after the final res_valid[N-1]; busy=0 in that same cycle; state returns to IDLE.
- Weights stay resident after a job, so a following cfg_reuse_w=1 job uses them.
- The first job after reset with cfg_reuse_w=1 is legal: it computes with zero weights.
- Counters saturate at their terminal values. There is no wrap within a job.

Optional Feature:
SA_CTRL_PERF_EN
- Defined: adds output perf_cycles (32 bits).
  - Cleared when a job is accepted.
  - Increments every cycle busy=1.
  - Holds its value after done until the next accept.
  - Reset value is 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package sa_pkg:
  - state enum sa_state_e {IDLE, LOAD_W, STREAM, DRAIN}
  - localparam functions for PIPE_DEPTH = 2N+1 and RES_TAP(c) = N+2+c
  - typedef for the row tag
- Sub-module sa_valid_pipe: a shift register of {valid, tag} with depth PIPE_DEPTH, N tap outputs and an empty flag. The FSM and counters stay in the top-level module.

Test Plan:
- N=4, start at cycle 0, cfg_m=3, reuse=0:
  - w_rd_en cycles 1-4, rows 3,2,1,0
  - weight_load_en cycles 2-5
  - a_rd_en cycles 6-8, rows 0,1,2
  - res_valid[0] at cycles 12-14, res_valid[3] at cycles 15-17
  - done at cycle 18, busy low at cycle 18
- Back-to-back job with cfg_reuse_w=1, cfg_m=1, start accepted at cycle 18:
  - no w_rd_en or weight_load_en
  - a_rd_en at cycle 19 only
  - res_valid[3] at cycle 28, done at cycle 29
- start with cfg_m=0 in IDLE -> err pulse next cycle, busy stays 0, no read strobes.
- start asserted again during STREAM -> ignored: no err, and the job timing is unchanged from scenario 1.
- rst=1 at cycle 7 of scenario 1 -> next cycle all outputs 0 and state IDLE; no done pulse; a new start then runs the scenario-1 timing again.
- With SA_CTRL_PERF_EN, scenario 1 -> perf_cycles reads 17 after done and holds that value.
